// File: rtl/slave_bus_router_if.sv
// Core-side request/response bus and per-slave fan-out bundle for slave_bus_router.
// slave modport is the router's view; master modport is the surrounding system's view.
interface slave_bus_router_if #(
  parameter int NUM_SLAVES = 2,
  parameter int CMD_W      = 4,
  parameter int RES_W      = 32
);
  logic                        m_valid;
  logic                        m_ready;
  logic [29:0]                 m_addr;
  logic                        m_we;
  logic [CMD_W-1:0]            m_cmd;
  logic                        m_rvalid;
  logic [RES_W-1:0]            m_result;
  logic                        m_err;
  logic [NUM_SLAVES-1:0]       s_valid;
  logic [NUM_SLAVES-1:0]       s_ready;
  logic [NUM_SLAVES*30-1:0]    s_addr;
  logic [NUM_SLAVES-1:0]       s_we;
  logic [NUM_SLAVES*CMD_W-1:0] s_cmd;
  logic [NUM_SLAVES-1:0]       s_rvalid;
  logic [NUM_SLAVES*RES_W-1:0] s_result;

  modport slave (
    input  m_valid, m_addr, m_we, m_cmd,
    output m_ready, m_rvalid, m_result, m_err,
    output s_valid, s_addr, s_we, s_cmd,
    input  s_ready, s_rvalid, s_result
  );

  modport master (
    output m_valid, m_addr, m_we, m_cmd,
    input  m_ready, m_rvalid, m_result, m_err,
    input  s_valid, s_addr, s_we, s_cmd,
    output s_ready, s_rvalid, s_result
  );
endinterface

// File: rtl/slave_bus_router.sv
// N-way window-decoded slave router, one outstanding transaction.
// Define SLAVE_TIMEOUT_EN to abort stalled slaves after TIMEOUT_CYCLES.
module slave_bus_router #(
  parameter int NUM_SLAVES = 2,
  parameter int CMD_W      = 4,
  parameter int RES_W      = 32,
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_BASE =
    {32'h0001_0000, 32'h0000_0000},
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_SIZE =
    {32'h0000_1000, 32'h0001_0000},
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               rst,
  slave_bus_router_if.slave  bus,
  output logic [7:0]         err_count
);
  localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  if (NUM_SLAVES < 1 || NUM_SLAVES > 8 ||
      TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_cfg
    $error("slave_bus_router: bad configuration");
  end

  typedef enum logic [1:0] {IDLE, REQ, RESP, ERR} state_e;

  state_e           state_q, state_d;
  logic [29:0]      addr_q, addr_d;
  logic             we_q, we_d;
  logic [CMD_W-1:0] cmd_q, cmd_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             m_rvalid_q, m_rvalid_d;
  logic             m_err_q, m_err_d;
  logic [RES_W-1:0] m_result_q, m_result_d;
  logic [7:0]       err_cnt_q, err_cnt_d;

  logic             hit;
  logic [SEL_W-1:0] hit_idx;
  logic [29:0]      hit_local;
  logic             tmo_hit;

  function automatic logic [29:0] win_mask(input int i);
    logic [31:0] w;
    w = (SLAVE_SIZE[i*32 +: 32] >> 2) - 32'd1;
    return w[29:0];
  endfunction

  // Descending scan so the lowest matching window wins.
  always_comb begin
    hit       = 1'b0;
    hit_idx   = '0;
    hit_local = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((bus.m_addr & ~win_mask(i)) ==
          (SLAVE_BASE[i*32+2 +: 30] & ~win_mask(i))) begin
        hit       = 1'b1;
        hit_idx   = SEL_W'(i);
        hit_local = bus.m_addr & win_mask(i);
      end
    end
  end

`ifdef SLAVE_TIMEOUT_EN
  logic [15:0] tmo_q, tmo_d;
  assign tmo_hit = (tmo_q == 16'(TIMEOUT_CYCLES));
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    we_d       = we_q;
    cmd_d      = cmd_q;
    sel_d      = sel_q;
    m_rvalid_d = 1'b0;
    m_err_d    = 1'b0;
    m_result_d = m_result_q;
    err_cnt_d  = err_cnt_q;
`ifdef SLAVE_TIMEOUT_EN
    tmo_d = (state_q == REQ || state_q == RESP) ? tmo_q + 16'd1 : tmo_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.m_valid) begin
          addr_d = hit_local;
          we_d   = bus.m_we;
          cmd_d  = bus.m_cmd;
          sel_d  = hit_idx;
          if (hit) begin
            state_d = REQ;
`ifdef SLAVE_TIMEOUT_EN
            tmo_d = '0;
`endif
          end else begin
            state_d    = ERR;
            m_rvalid_d = 1'b1;
            m_err_d    = 1'b1;
            m_result_d = '0;
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
          end
        end
      end
      REQ: begin
        if (bus.s_ready[sel_q]) begin
          state_d = RESP;
        end else if (tmo_hit) begin
          state_d    = IDLE;
          m_rvalid_d = 1'b1;
          m_err_d    = 1'b1;
          m_result_d = '0;
          if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
        end
      end
      RESP: begin
        if (bus.s_rvalid[sel_q]) begin
          state_d    = IDLE;
          m_rvalid_d = 1'b1;
          m_result_d = bus.s_result[sel_q*RES_W +: RES_W];
        end else if (tmo_hit) begin
          state_d    = IDLE;
          m_rvalid_d = 1'b1;
          m_err_d    = 1'b1;
          m_result_d = '0;
          if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
        end
      end
      ERR: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      we_q       <= 1'b0;
      cmd_q      <= '0;
      sel_q      <= '0;
      m_rvalid_q <= 1'b0;
      m_err_q    <= 1'b0;
      m_result_q <= '0;
      err_cnt_q  <= '0;
`ifdef SLAVE_TIMEOUT_EN
      tmo_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      cmd_q      <= cmd_d;
      sel_q      <= sel_d;
      m_rvalid_q <= m_rvalid_d;
      m_err_q    <= m_err_d;
      m_result_q <= m_result_d;
      err_cnt_q  <= err_cnt_d;
`ifdef SLAVE_TIMEOUT_EN
      tmo_q      <= tmo_d;
`endif
    end
  end

  // Slave-side outputs come only from latched copies, so they hold during stalls.
  always_comb begin
    bus.s_valid = '0;
    bus.s_addr  = '0;
    bus.s_we    = '0;
    bus.s_cmd   = '0;
    if (state_q == REQ) begin
      bus.s_valid[sel_q]              = 1'b1;
      bus.s_addr[sel_q*30 +: 30]      = addr_q;
      bus.s_we[sel_q]                 = we_q;
      bus.s_cmd[sel_q*CMD_W +: CMD_W] = cmd_q;
    end
  end

  assign bus.m_ready  = (state_q == IDLE);
  assign bus.m_rvalid = m_rvalid_q;
  assign bus.m_err    = m_err_q;
  assign bus.m_result = m_result_q;
  assign err_count    = err_cnt_q;
endmodule
